// File: rtl/instr_encoder.sv
// RV64 load/store/branch instruction encoder feeding an address-tagged output FIFO.
// Define IMMENC_RANGE_CHECK_EN to also reject immediates that do not fit 12-bit signed.
module instr_encoder #(
    parameter logic [63:0] BASE_ADDR = 64'h0,
    parameter int unsigned DEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_type,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [2:0]  in_funct3,
    input  logic [63:0] in_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [63:0] out_addr,
    output logic        err_pulse,
    output logic [7:0]  err_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        TYPE_I   = 2'b00,
        TYPE_S   = 2'b01,
        TYPE_SB  = 2'b10,
        TYPE_ILL = 2'b11
    } instr_type_e;

    logic [31:0]   mem_instr_q [DEPTH];
    logic [31:0]   mem_instr_d [DEPTH];
    logic [63:0]   mem_addr_q  [DEPTH];
    logic [63:0]   mem_addr_d  [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   next_addr_q, next_addr_d;
    logic          err_pulse_q, err_pulse_d;
    logic [7:0]    err_count_q, err_count_d;

    instr_type_e   req_type;
    logic [11:0]   imm12;
    logic [31:0]   instr;
    logic          range_bad;
    logic          accept, reject, push, pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign req_type = instr_type_e'(in_type);
    assign imm12    = in_imm[11:0];

`ifdef IMMENC_RANGE_CHECK_EN
    assign range_bad = (in_imm[63:11] != {53{in_imm[11]}});
`else
    logic unused_imm_hi;
    assign unused_imm_hi = ^in_imm[63:12];
    assign range_bad     = 1'b0;
`endif

    // SB immediate is in halfwords: imm[k] lands where byte-offset bit k+1 would.
    always_comb begin
        instr = '0;
        case (req_type)
            TYPE_I:  instr = {imm12, in_rs1, in_funct3, in_rd, 7'b0000011};
            TYPE_S:  instr = {imm12[11:5], in_rs2, in_rs1, in_funct3, imm12[4:0], 7'b0100011};
            TYPE_SB: instr = {imm12[11], imm12[9:4], in_rs2, in_rs1, in_funct3,
                              imm12[3:0], imm12[10], 7'b1100011};
            default: instr = '0;
        endcase
    end

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? mem_instr_q[rd_ptr_q] : '0;
    assign out_addr  = out_valid ? mem_addr_q[rd_ptr_q]  : '0;
    assign err_pulse = err_pulse_q;
    assign err_count = err_count_q;

    assign accept = in_valid & in_ready;
    assign reject = (req_type == TYPE_ILL) | range_bad;
    assign push   = accept & ~reject;
    assign pop    = out_valid & out_ready;

    always_comb begin
        mem_instr_d = mem_instr_q;
        mem_addr_d  = mem_addr_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        next_addr_d = next_addr_q;
        err_count_d = err_count_q;
        err_pulse_d = accept & reject;
        count_d     = count_q + CW'(push) - CW'(pop);

        if (push) begin
            mem_instr_d[wr_ptr_q] = instr;
            mem_addr_d[wr_ptr_q]  = next_addr_q;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
            next_addr_d           = next_addr_q + 64'd4;
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        if (accept && reject && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_instr_q <= '{default: '0};
            mem_addr_q  <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            next_addr_q <= BASE_ADDR;
            err_pulse_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            mem_instr_q <= mem_instr_d;
            mem_addr_q  <= mem_addr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            next_addr_q <= next_addr_d;
            err_pulse_q <= err_pulse_d;
            err_count_q <= err_count_d;
        end
    end

endmodule
